// File: rtl/face_instr_seq.sv
// Instruction sequencer for the FACE systolic engine: buffers host instructions
// and issues them one cycle at a time, holding back while a calc is running.
module face_instr_seq #(
  parameter int         DEPTH         = 8,
  parameter logic [6:0] SYS_OPCODE    = 7'h0B,
  parameter logic [2:0] ADDRSET_FUNC  = 3'd0,
  parameter logic [2:0] CALC_FUNC     = 3'd1,
  parameter int         START_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] instr_o,
  input  logic        engine_busy,
  output logic        seq_busy,
  output logic        done_pulse,
  output logic [15:0] issued_cnt,
  output logic        err_illegal,
  output logic        err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE} state_t;

  function automatic logic is_legal(input logic [9:0] ins);
    return (ins[6:0] == SYS_OPCODE) &&
           ((ins[9:7] == ADDRSET_FUNC) || (ins[9:7] == CALC_FUNC));
  endfunction

  state_t          state, state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            head_vld_p0;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     head, instr_d;
  logic            full, push, pop, head_legal, timer_last;
  logic            done_d, cnt_inc, illegal_set, timeout_set;

  assign full       = (count == CW'(DEPTH));
  assign in_ready   = !full;
  assign push       = in_valid && !full && !flush;
  assign head       = mem[rd_ptr];
  assign head_legal = is_legal(head[9:0]);
  assign timer_last = (timer_q == TW'(START_TIMEOUT - 1));
  // A freshly written entry becomes eligible one cycle after it lands.
  assign pop        = (state == S_IDLE) && head_vld_p0 && (count != '0) &&
                      !engine_busy && !flush;
  assign seq_busy   = (count != '0) || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      head_vld_p0 <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      head_vld_p0 <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= count + CW'(push) - CW'(pop);
      head_vld_p0 <= (count != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (pop && head_legal) state_nxt = S_ISSUE;
      S_ISSUE:      state_nxt = (instr_o[9:7] == CALC_FUNC) ? S_WAIT_START : S_IDLE;
      S_WAIT_START: if (engine_busy)     state_nxt = S_WAIT_DONE;
                    else if (timer_last) state_nxt = S_IDLE;
      S_WAIT_DONE:  if (!engine_busy)    state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    instr_d     = (state == S_IDLE && pop && head_legal) ? head : 32'd0;
    done_d      = (state == S_WAIT_DONE) && !engine_busy;
    cnt_inc     = (state == S_ISSUE);
    illegal_set = (state == S_IDLE) && pop && !head_legal;
    timeout_set = (state == S_WAIT_START) && !engine_busy && timer_last;
    timer_d     = (state == S_WAIT_START && !engine_busy) ? timer_q + TW'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_o     <= 32'd0;
      done_pulse  <= 1'b0;
      issued_cnt  <= 16'd0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      timer_q     <= '0;
    end else begin
      instr_o    <= instr_d;
      done_pulse <= done_d;
      timer_q    <= timer_d;
      if (cnt_inc)     issued_cnt  <= issued_cnt + 16'd1;
      if (illegal_set) err_illegal <= 1'b1;
      if (timeout_set) err_timeout <= 1'b1;
    end
  end

endmodule
